// File: rtl/gyro_axis_filter.sv
// rtl/gyro_axis_filter.sv - per-axis moving-average filter for gyro X/Y/Z rates
//
// Samples the three signed gyro axes every CLK_DIV cycles while EN is high,
// keeps a running sum over the last 2^LOG2_DEPTH samples of each axis and
// publishes the floored averages with a one-cycle VALID strobe. MOTION flags
// any averaged axis whose magnitude exceeds THRESH.
//
// Ports:
//   CLK                  system clock
//   RST                  synchronous active-high reset
//   EN                   sampling enable (0 holds the sample timer at 0)
//   X, Y, Z              signed 16-bit axis rates from the gyro front end
//   X_AVG, Y_AVG, Z_AVG  signed windowed averages
//   VALID                one-cycle pulse when the averages update
//   MOTION               level, 1 when any |average| > THRESH
module gyro_axis_filter #(
  parameter int          CLK_DIV    = 100000,
  parameter int          LOG2_DEPTH = 3,
  parameter logic [15:0] THRESH     = 16'd1000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic signed [15:0] X,
  input  logic signed [15:0] Y,
  input  logic signed [15:0] Z,
  output logic signed [15:0] X_AVG,
  output logic signed [15:0] Y_AVG,
  output logic signed [15:0] Z_AVG,
  output logic               VALID,
  output logic               MOTION
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = 16 + LOG2_DEPTH;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_ACCUM   = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH:0]   fill;
  logic                  full;
  logic                  full_next;

  logic signed [15:0] smp_x, smp_y, smp_z;
  logic signed [15:0] old_x, old_y, old_z;

  logic signed [SUM_W-1:0] sum_x, sum_y, sum_z;
  logic signed [SUM_W-1:0] nxt_x, nxt_y, nxt_z;
  logic signed [15:0]      avg_x, avg_y, avg_z;
  logic                    motion_next;

  // Ring buffers hold raw samples; they are never reset because the sums
  // only subtract the oldest entry once the window has been refilled.
  logic signed [15:0] buf_x [DEPTH];
  logic signed [15:0] buf_y [DEPTH];
  logic signed [15:0] buf_z [DEPTH];

  function automatic logic signed [SUM_W-1:0] sum_step(
    input logic signed [SUM_W-1:0] s,
    input logic signed [15:0]      n,
    input logic signed [15:0]      o,
    input logic                    sub
  );
    logic signed [SUM_W-1:0] n_ext;
    logic signed [SUM_W-1:0] o_ext;
    n_ext = {{LOG2_DEPTH{n[15]}}, n};
    o_ext = sub ? {{LOG2_DEPTH{o[15]}}, o} : '0;
    return s + n_ext - o_ext;
  endfunction

  // 17-bit magnitude so that -32768 maps to 32768 instead of wrapping.
  function automatic logic [16:0] mag17(input logic signed [15:0] v);
    return v[15] ? (17'd0 - {v[15], v}) : {1'b0, v};
  endfunction

  assign tick      = EN && (cnt == CNT_MAX);
  assign full      = (fill == FILL_MAX);
  assign full_next = full || (fill == FILL_MAX - 1'b1);

  assign nxt_x = sum_step(sum_x, smp_x, old_x, full);
  assign nxt_y = sum_step(sum_y, smp_y, old_y, full);
  assign nxt_z = sum_step(sum_z, smp_z, old_z, full);

  // Dropping the low LOG2_DEPTH bits of a two's complement sum is an
  // arithmetic shift, i.e. division rounding toward -infinity. The window
  // average always fits in 16 bits, so the top 16 bits are the result.
  assign avg_x = nxt_x[LOG2_DEPTH +: 16];
  assign avg_y = nxt_y[LOG2_DEPTH +: 16];
  assign avg_z = nxt_z[LOG2_DEPTH +: 16];

  assign motion_next = (mag17(avg_x) > {1'b0, THRESH}) ||
                       (mag17(avg_y) > {1'b0, THRESH}) ||
                       (mag17(avg_z) > {1'b0, THRESH});

  // The averages are computed from the sums being written at the end of
  // ACCUM and registered on the same edge, so they and VALID become visible
  // together during the PUBLISH cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      sum_z  <= '0;
      smp_x  <= '0;
      smp_y  <= '0;
      smp_z  <= '0;
      old_x  <= '0;
      old_y  <= '0;
      old_z  <= '0;
      X_AVG  <= '0;
      Y_AVG  <= '0;
      Z_AVG  <= '0;
      VALID  <= 1'b0;
      MOTION <= 1'b0;
    end else begin
      if (!EN || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      VALID <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          smp_x <= X;
          smp_y <= Y;
          smp_z <= Z;
          old_x <= buf_x[wr_ptr];
          old_y <= buf_y[wr_ptr];
          old_z <= buf_z[wr_ptr];
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          sum_x  <= nxt_x;
          sum_y  <= nxt_y;
          sum_z  <= nxt_z;
          wr_ptr <= wr_ptr + 1'b1;
          if (!full) begin
            fill <= fill + 1'b1;
          end
          if (full_next) begin
            X_AVG  <= avg_x;
            Y_AVG  <= avg_y;
            Z_AVG  <= avg_z;
            MOTION <= motion_next;
            VALID  <= 1'b1;
          end
          state <= S_PUBLISH;
        end
        S_PUBLISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && (state == S_ACCUM)) begin
      buf_x[wr_ptr] <= smp_x;
      buf_y[wr_ptr] <= smp_y;
      buf_z[wr_ptr] <= smp_z;
    end
  end

endmodule

// File: tb/tb_gyro_axis_filter.sv
// tb/tb_gyro_axis_filter.sv - self-checking bench for gyro_axis_filter
module tb_gyro_axis_filter;

  localparam int          CLK_DIV    = 4;
  localparam int          LOG2_DEPTH = 2;
  localparam int          DEPTH      = 4;
  localparam logic [15:0] THRESH     = 16'd150;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [15:0] x, y, z;
  logic signed [15:0] x_avg, y_avg, z_avg;
  logic               valid, motion;

  always #5 clk = ~clk;

  gyro_axis_filter #(
    .CLK_DIV   (CLK_DIV),
    .LOG2_DEPTH(LOG2_DEPTH),
    .THRESH    (THRESH)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .X     (x),
    .Y     (y),
    .Z     (z),
    .X_AVG (x_avg),
    .Y_AVG (y_avg),
    .Z_AVG (z_avg),
    .VALID (valid),
    .MOTION(motion)
  );

  logic [49:0] act_vec;
  assign act_vec = {valid, motion, x_avg, y_avg, z_avg};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid_obs = 0;

  // Reference model: a sample timer, a four-step sequence per tick and a
  // plain queue holding the last DEPTH samples of each axis since reset.
  int          mcnt = 0;
  int          mstage = 0;
  bit          cap_now = 0;
  int          cap_x, cap_y, cap_z;
  int          hx[$], hy[$], hz[$];
  logic        exp_valid = 0, exp_motion = 0;
  logic [15:0] exp_xa = 0, exp_ya = 0, exp_za = 0;
  logic [49:0] exp_vec = '0;

  function automatic int floor_avg(int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    if (s < 0 && (s % DEPTH) != 0) return s / DEPTH - 1;
    return s / DEPTH;
  endfunction

  function automatic bit over(int a);
    return ((a < 0) ? -a : a) > int'(THRESH);
  endfunction

  task automatic step();
    bit tick;
    int ax, ay, az;
    cap_now = 0;
    tick = en && (mcnt == CLK_DIV - 1);
    if (rst) begin
      mcnt = 0; mstage = 0;
      hx.delete(); hy.delete(); hz.delete();
      exp_valid = 0; exp_motion = 0; exp_xa = 0; exp_ya = 0; exp_za = 0;
    end else begin
      exp_valid = 0;
      mcnt = (!en || tick) ? 0 : mcnt + 1;
      case (mstage)
        0: if (tick) mstage = 1;
        1: begin
          cap_x = x; cap_y = y; cap_z = z;
          cap_now = 1;
          mstage = 2;
        end
        2: begin
          hx.push_back(cap_x); hy.push_back(cap_y); hz.push_back(cap_z);
          if (hx.size() > DEPTH) begin
            void'(hx.pop_front()); void'(hy.pop_front()); void'(hz.pop_front());
          end
          if (hx.size() == DEPTH) begin
            ax = floor_avg(hx); ay = floor_avg(hy); az = floor_avg(hz);
            exp_xa = ax[15:0]; exp_ya = ay[15:0]; exp_za = az[15:0];
            exp_motion = over(ax) || over(ay) || over(az);
            exp_valid = 1;
          end
          mstage = 3;
        end
        default: mstage = 0;
      endcase
    end
    exp_vec = {exp_valid, exp_motion, exp_xa, exp_ya, exp_za};
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) nvalid_obs++;
  endtask

  task automatic feed(input int vx, input int vy, input int vz, input string tag);
    int n = 0;
    x = 16'(vx); y = 16'(vy); z = 16'(vz);
    do begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act_vec, exp_vec);
      end
      n++;
    end while (!cap_now && n < 40);
    checks++;
    if (!cap_now) begin
      errors++;
      $display("FAIL %s_capture_timeout got=no_capture want=capture", tag);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act_vec, exp_vec);
      end
      n++;
    end while (valid !== 1'b1 && n < 12);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout got=%b want=1", tag, valid);
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; x = 0; y = 0; z = 0;
    step();
    step();
    checks++;
    if (act_vec !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", act_vec, 50'd0);
    end
    rst = 0;
  endtask

  task automatic test_fill_constant();
    int first = -1, last = 0, nv = 0;
    en = 1; x = 100; y = -200; z = 0;
    for (int n = 1; n <= 26; n++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL fill cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
      end
      if (valid === 1'b1) begin
        nv++;
        if (first < 0) begin
          first = n;
          checks++;
          if ({x_avg, y_avg, z_avg, motion} !== {16'd100, 16'hFF38, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL fill_first_avg got=%h %h %h m=%b want=0064 ff38 0000 m=1",
                     x_avg, y_avg, z_avg, motion);
          end
        end else begin
          checks++;
          if (n - last != CLK_DIV) begin
            errors++;
            $display("FAIL fill_spacing got=%0d want=%0d", n - last, CLK_DIV);
          end
        end
        last = n;
      end
    end
    checks++;
    if (first != 18 || nv != 3) begin
      errors++;
      $display("FAIL fill_first_valid got=cycle%0d count%0d want=cycle18 count3", first, nv);
    end
  endtask

  task automatic test_step_response();
    int want_x[4] = '{125, 150, 175, 200};
    bit want_m[4] = '{0, 0, 1, 1};
    int k = 0;
    x = 200; y = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL step_model cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
      end
      if (valid === 1'b1 && k < 4) begin
        checks++;
        if (x_avg !== 16'(want_x[k]) || motion !== want_m[k]) begin
          errors++;
          $display("FAIL step_resp%0d got=x%0d m%b want=x%0d m%b", k, x_avg, motion, want_x[k], want_m[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL step_valid_count got=%0d want=4", k);
    end
  endtask

  task automatic test_floor_extremes();
    rst = 1;
    step();
    rst = 0;
    feed(-1, 0, 0, "floor_s0");
    for (int i = 1; i < 4; i++) feed(0, 0, 0, "floor_sn");
    wait_valid("floor");
    checks++;
    if (x_avg !== 16'hFFFF) begin
      errors++;
      $display("FAIL floor_neg got=%h want=ffff", x_avg);
    end
    for (int i = 0; i < 4; i++) feed(-32768, -32768, -32768, "extreme");
    wait_valid("extreme");
    checks++;
    if ({x_avg, y_avg, z_avg, motion} !== {16'h8000, 16'h8000, 16'h8000, 1'b1}) begin
      errors++;
      $display("FAIL extreme_avg got=%h %h %h m=%b want=8000 8000 8000 m=1", x_avg, y_avg, z_avg, motion);
    end
  endtask

  task automatic test_enable_gap();
    int base, n;
    feed(int'($urandom_range(0, 65535)) - 32768, 120, -90, "gap_pre0");
    feed(int'($urandom_range(0, 400)) - 200, -300, 40, "gap_pre1");
    wait_valid("gap_pre");
    en = 0;
    base = nvalid_obs;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL gap_model cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
      end
    end
    checks++;
    if (nvalid_obs != base) begin
      errors++;
      $display("FAIL gap_no_valid got=%0d want=0", nvalid_obs - base);
    end
    checks++;
    if (dut.cnt !== '0) begin
      errors++;
      $display("FAIL gap_counter_held got=%0d want=0", dut.cnt);
    end
    en = 1;
    n = 0;
    do begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL gap_resume cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
      end
      n++;
    end while (valid !== 1'b1 && n < 12);
    checks++;
    if (n != 6 || valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_first_valid got=%0d cycles want=6", n);
    end
    feed(int'($urandom_range(0, 600)) - 300, 10, 20, "gap_post");
    wait_valid("gap_post");
  endtask

  task automatic test_reset_mid();
    int q_x[$], q_y[$], q_z[$];
    int base, vx, vy, vz;
    for (int i = 0; i < 3; i++)
      feed(int'($urandom_range(0, 65535)) - 32768, 500, -700, "rstmid_pre");
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (act_vec !== 50'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got=%h want=%h", act_vec, 50'd0);
    end
    base = nvalid_obs;
    for (int i = 0; i < 4; i++) begin
      vx = int'($urandom_range(0, 65535)) - 32768;
      vy = int'($urandom_range(0, 1000)) - 500;
      vz = int'($urandom_range(0, 300)) - 150;
      q_x.push_back(vx); q_y.push_back(vy); q_z.push_back(vz);
      feed(vx, vy, vz, "rstmid_fill");
    end
    checks++;
    if (nvalid_obs != base) begin
      errors++;
      $display("FAIL rstmid_early_valid got=%0d want=0", nvalid_obs - base);
    end
    wait_valid("rstmid");
    vx = floor_avg(q_x); vy = floor_avg(q_y); vz = floor_avg(q_z);
    checks++;
    if ({x_avg, y_avg, z_avg} !== {vx[15:0], vy[15:0], vz[15:0]}) begin
      errors++;
      $display("FAIL rstmid_avg got=%h %h %h want=%h %h %h", x_avg, y_avg, z_avg, vx[15:0], vy[15:0], vz[15:0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
      end else begin
        x = 16'(int'($urandom_range(0, 600)) - 300);
        y = 16'(int'($urandom_range(0, 600)) - 300);
        z = 16'(int'($urandom_range(0, 600)) - 300);
      end
      en  = ($urandom_range(0, 24) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_fill_constant();
    test_step_response();
    test_floor_extremes();
    test_enable_gap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gyro_axis_filter.md
# gyro_axis_filter

Downstream consumer of the gyro SPI front end's X/Y/Z outputs. Samples the three signed 16-bit axis values at a fixed rate and keeps a per-axis moving average over the last 2^LOG2_DEPTH samples. Publishes the averages with a one-cycle valid strobe and raises a motion flag when any averaged axis exceeds a magnitude threshold. The filtered values feed display and control logic, so they never see raw, jittery gyro reads.

## Interface

Parameters:
- CLK_DIV, 100000: sample period in CLK cycles. Minimum legal value is 4.
- LOG2_DEPTH, 3: log2 of the averaging window. Legal values are 1 to 6.
- THRESH, 16'd1000: unsigned magnitude threshold for MOTION.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous, active-high reset.
- EN, in, 1: sampling enable.
- X, in, 16: signed X-axis rate, continuously driven by the gyro front end.
- Y, in, 16: signed Y-axis rate.
- Z, in, 16: signed Z-axis rate.
- X_AVG, out, 16: signed windowed average of X.
- Y_AVG, out, 16: signed windowed average of Y.
- Z_AVG, out, 16: signed windowed average of Z.
- VALID, out, 1: one-cycle pulse when the *_AVG outputs update.
- MOTION, out, 1: level output; 1 when any |avg| > THRESH.

## Operation

**Sample timer**
- Counter runs 0..CLK_DIV-1 while EN=1.
- TICK fires when the counter equals CLK_DIV-1 and EN=1; the counter then wraps to 0.
- EN=0 holds the counter at 0. No ticks occur.

**State machine: IDLE → CAPTURE → ACCUM → PUBLISH → IDLE**
- IDLE: wait for TICK.
- CAPTURE: register X, Y and Z. Read the oldest entry at the write pointer from each axis ring buffer (depth 2^LOG2_DEPTH).
- ACCUM: update each sum as sum + new − (full ? oldest : 0). Write the new sample at the write pointer. Advance the pointer modulo the depth. Increment the fill count, saturating at the depth; `full` is set when the fill count reaches the depth.
- PUBLISH: if full, set *_AVG = sum >>> LOG2_DEPTH, pulse VALID and update MOTION. If not full, outputs hold and VALID stays 0.

**Arithmetic**
- Sums are signed, 16+LOG2_DEPTH bits wide, and cannot overflow.
- The arithmetic shift floors, so results round toward −∞.
- Magnitude is computed in 17 bits, so |−32768| = 32768.
- MOTION = (|X_AVG| > THRESH) | (|Y_AVG| > THRESH) | (|Z_AVG| > THRESH), computed from the new averages.

**Buffers**
- Buffer contents are not reset. Stale data is never subtracted, because subtraction is gated by `full`.

**Boundary conditions**
- EN falling mid-sequence: the in-flight CAPTURE/ACCUM/PUBLISH sequence completes.
- RST at any cycle returns to IDLE and clears the counter, sums, pointer, fill count and all outputs. The next VALID requires 2^LOG2_DEPTH fresh samples.
- A TICK cannot arrive in a non-IDLE state, since CLK_DIV ≥ 4.

## Timing

**Reset values**
- X_AVG = Y_AVG = Z_AVG = 0.
- VALID = 0, MOTION = 0.
- State = IDLE, counter = 0.

**Sample timing**
- With EN=1 from the first cycle after reset, the first TICK occurs at cycle CLK_DIV-1 after reset release, counting the first post-reset cycle as cycle 0.
- Subsequent ticks occur every CLK_DIV cycles.
- X, Y and Z are sampled in the cycle after TICK (CAPTURE).

**Latency and pulses**
- VALID is high exactly in the PUBLISH cycle, 3 cycles after the TICK cycle, and lasts 1 cycle.
- *_AVG and MOTION change only in the VALID cycle.
- The first VALID after reset or initial fill comes on the 2^LOG2_DEPTH-th tick.

## Test plan

All scenarios use CLK_DIV=4, LOG2_DEPTH=2 and THRESH=150.

1. **Fill and constant input.** X=100, Y=−200, Z=0, EN=1. Require: no VALID on ticks 1–3; VALID on tick 4 with X_AVG=100, Y_AVG=16'hFF38, Z_AVG=0, MOTION=1 (|−200| > 150); VALID exactly every 4 cycles thereafter.
2. **Step response.** After scenario 1, set X=200 and Y=0. Require successive X_AVG = 125, 150, 175, 200, with MOTION = 0, 0, 1, 1 across those four VALIDs.
3. **Floor rounding and extremes.** From reset, feed X samples −1, 0, 0, 0: require X_AVG=16'hFFFF. Then feed four samples of 16'h8000 on all axes: require averages of 16'h8000 and MOTION=1.
4. **Enable gating.** Drop EN for 20 cycles mid-stream. Require no VALID during the gap and the counter held at 0. After EN returns, the first TICK comes 3 cycles later and the averages continue with no lost or duplicated window state.
5. **Reset mid-operation.** Assert RST during the ACCUM cycle after 3 samples. Require all outputs 0 the next cycle, and the first subsequent VALID only after 4 new ticks, with averages reflecting only post-reset samples.
